// File: rtl/idex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX hazard stage.
//   state_t       : FSM encoding (ST_RUN, ST_STALL)
//   OP_*          : opcode constants used by decode and the bench
//   *_DEFAULT     : default field widths for the stage and its interface
//   STALL_CNT_W   : width of the internal bubble down-counter (covers 1..7)
package idex_hazard_stage_pkg;

  localparam int unsigned REG_W_DEFAULT  = 32;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT  = 32;
  localparam int unsigned STALL_CNT_W    = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/idex_hazard_stage_if.sv
// Decode-to-execute bus for the ID/EX stage.
//   ID_*     : decoded instruction presented by the decode stage
//   EX_Flush : taken branch/jump resolved in EX, kills the decode slot
//   IDEX_*   : registered copy of the ID_* fields feeding EX and forwarding
//   Stall    : hold PC and IF/ID this cycle
// Modports: slave = the ID/EX stage, master = decode/execute side.
interface idex_hazard_stage_if
  import idex_hazard_stage_pkg::*;
#(
  parameter int unsigned REG_W  = REG_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);

  logic              ID_Valid;
  logic [REG_W-1:0]  ID_RegisterRs;
  logic [REG_W-1:0]  ID_RegisterRt;
  logic [REG_W-1:0]  ID_RegisterRd;
  logic [REG_W-1:0]  ID_RegDstAddr;
  logic              ID_UsesRs;
  logic              ID_UsesRt;
  logic [DATA_W-1:0] ID_ReadData1;
  logic [DATA_W-1:0] ID_ReadData2;
  logic [DATA_W-1:0] ID_Imm;
  logic [5:0]        ID_OpCode;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_MemWrite;
  logic              ID_MemToReg;
  logic [1:0]        ID_ALUSrc0;
  logic [1:0]        ID_ALUSrc1;
  logic              EX_Flush;

  logic              IDEX_Valid;
  logic [REG_W-1:0]  IDEX_RegisterRs;
  logic [REG_W-1:0]  IDEX_RegisterRt;
  logic [REG_W-1:0]  IDEX_RegisterRd;
  logic [REG_W-1:0]  IDEX_RegDstAddr;
  logic              IDEX_UsesRs;
  logic              IDEX_UsesRt;
  logic [DATA_W-1:0] IDEX_ReadData1;
  logic [DATA_W-1:0] IDEX_ReadData2;
  logic [DATA_W-1:0] IDEX_Imm;
  logic [5:0]        IDEX_OpCode;
  logic              IDEX_RegWrite;
  logic              IDEX_MemRead;
  logic              IDEX_MemWrite;
  logic              IDEX_MemToReg;
  logic [1:0]        IDEX_ALUSrc0;
  logic [1:0]        IDEX_ALUSrc1;
  logic              Stall;

  modport slave (
    input  ID_Valid, ID_RegisterRs, ID_RegisterRt, ID_RegisterRd, ID_RegDstAddr,
           ID_UsesRs, ID_UsesRt, ID_ReadData1, ID_ReadData2, ID_Imm, ID_OpCode,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc0, ID_ALUSrc1,
           EX_Flush,
    output IDEX_Valid, IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd, IDEX_RegDstAddr,
           IDEX_UsesRs, IDEX_UsesRt, IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm, IDEX_OpCode,
           IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc0, IDEX_ALUSrc1,
           Stall
  );

  modport master (
    output ID_Valid, ID_RegisterRs, ID_RegisterRt, ID_RegisterRd, ID_RegDstAddr,
           ID_UsesRs, ID_UsesRt, ID_ReadData1, ID_ReadData2, ID_Imm, ID_OpCode,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc0, ID_ALUSrc1,
           EX_Flush,
    input  IDEX_Valid, IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd, IDEX_RegDstAddr,
           IDEX_UsesRs, IDEX_UsesRt, IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm, IDEX_OpCode,
           IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc0, IDEX_ALUSrc1,
           Stall
  );

endinterface

// File: rtl/idex_hazard_stage_load_use_detect.sv
// Load-use hazard compare (pure combinational).
//   idValid/idUsesRs/idUsesRt/idRs/idRt : instruction in decode
//   exValid/exMemRead/exRegWrite/exDst  : instruction currently in ID/EX
//   hazard : decode reads the register a load in EX has not produced yet
module load_use_detect #(
  parameter int unsigned REG_W = 32
) (
  input  logic             idValid,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [REG_W-1:0] exDst,
  output logic             hazard
);

  logic loadInEx;
  logic rsMatch;
  logic rtMatch;

  // Register 0 is hardwired, so a load targeting it never produces a value to wait for.
  assign loadInEx = exValid & exMemRead & exRegWrite & (exDst != '0);
  assign rsMatch  = idUsesRs & (idRs == exDst);
  assign rtMatch  = idUsesRt & (idRt == exDst);
  assign hazard   = idValid & loadInEx & (rsMatch | rtMatch);

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion and flush.
//   Clk         : rising-edge clock
//   Rst         : asynchronous active-low reset
//   bus         : decode inputs, registered IDEX_* outputs, combinational Stall
//   StallCycles : saturating count of cycles with Stall asserted
// LOAD_STALL_CYCLES (1..7) bubbles are inserted per load-use hazard; a flush
// always wins over a stall and drops the decode slot as a bubble.
module idex_hazard_stage
  import idex_hazard_stage_pkg::*;
#(
  parameter int unsigned REG_W             = REG_W_DEFAULT,
  parameter int unsigned DATA_W            = DATA_W_DEFAULT,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = CNT_W_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  idex_hazard_stage_if.slave    bus,
  output logic [CNT_W-1:0]      StallCycles
);

  localparam int unsigned BUNDLE_W = 4 * REG_W + 3 * DATA_W + 17;
  localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);

  state_t                 state;
  logic [STALL_CNT_W-1:0] cnt;
  logic                   hazard;
  logic                   stallNow;
  logic                   bubble;
  logic [BUNDLE_W-1:0]    idBundle;
  logic [BUNDLE_W-1:0]    idexBundle;

  // All ID fields travel as one vector so capture, bubble and reset stay a single
  // assignment each; field order is identical on both sides.
  assign idBundle = {bus.ID_Valid, bus.ID_RegisterRs, bus.ID_RegisterRt, bus.ID_RegisterRd,
                     bus.ID_RegDstAddr, bus.ID_UsesRs, bus.ID_UsesRt, bus.ID_ReadData1,
                     bus.ID_ReadData2, bus.ID_Imm, bus.ID_OpCode, bus.ID_RegWrite,
                     bus.ID_MemRead, bus.ID_MemWrite, bus.ID_MemToReg, bus.ID_ALUSrc0,
                     bus.ID_ALUSrc1};

  assign {bus.IDEX_Valid, bus.IDEX_RegisterRs, bus.IDEX_RegisterRt, bus.IDEX_RegisterRd,
          bus.IDEX_RegDstAddr, bus.IDEX_UsesRs, bus.IDEX_UsesRt, bus.IDEX_ReadData1,
          bus.IDEX_ReadData2, bus.IDEX_Imm, bus.IDEX_OpCode, bus.IDEX_RegWrite,
          bus.IDEX_MemRead, bus.IDEX_MemWrite, bus.IDEX_MemToReg, bus.IDEX_ALUSrc0,
          bus.IDEX_ALUSrc1} = idexBundle;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .idValid    (bus.ID_Valid),
    .idUsesRs   (bus.ID_UsesRs),
    .idUsesRt   (bus.ID_UsesRt),
    .idRs       (bus.ID_RegisterRs),
    .idRt       (bus.ID_RegisterRt),
    .exValid    (bus.IDEX_Valid),
    .exMemRead  (bus.IDEX_MemRead),
    .exRegWrite (bus.IDEX_RegWrite),
    .exDst      (bus.IDEX_RegDstAddr),
    .hazard     (hazard)
  );

  always_comb begin
    stallNow = 1'b0;
    bubble   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (bus.EX_Flush) begin
          bubble = 1'b1;
        end else if (hazard) begin
          stallNow = 1'b1;
          bubble   = 1'b1;
        end
      end
      ST_STALL: begin
        bubble   = 1'b1;
        stallNow = ~bus.EX_Flush;
      end
      default: begin
        bubble = 1'b1;
      end
    endcase
  end

  // Gating with Rst keeps Stall low for the whole reset window, not just after the first edge.
  assign bus.Stall = Rst & stallNow;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= ST_RUN;
      cnt         <= '0;
      idexBundle  <= '0;
      StallCycles <= '0;
    end else begin
      idexBundle <= bubble ? '0 : idBundle;

      unique case (state)
        ST_RUN: begin
          if (!bus.EX_Flush && hazard && (LOAD_STALL_CYCLES > 1)) begin
            state <= ST_STALL;
            cnt   <= STALL_RELOAD;
          end
        end
        ST_STALL: begin
          if (bus.EX_Flush) begin
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            cnt <= cnt - STALL_CNT_W'(1);
            if (cnt == STALL_CNT_W'(1)) begin
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase

      if (stallNow && (StallCycles != '1)) begin
        StallCycles <= StallCycles + CNT_W'(1);
      end
    end
  end

endmodule
